// File: rtl/adc_frame_scheduler.sv
// adc_frame_scheduler: once per sample period, requests one ADC conversion per
// channel in ascending order, streams each 12-bit result to the UART as a low
// byte and an upper byte (tagged with the channel ID), then sends a terminator.
// Optional build macro: ADC_FRAME_SCHED_TIMEOUT_EN adds a conversion-done
// timeout that substitutes 12'hFFF and raises the sticky adc_timeout flag.
module adc_frame_scheduler #(
  parameter int unsigned NUM_CH         = 3,
  parameter int unsigned PERIOD_CYCLES  = 50000,
  parameter logic [7:0]  TERM_BYTE      = 8'h0A,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_50,
  input  logic        reset,
  input  logic        enable,
  input  logic        overrun_clr,
  output logic        adc_start,
  output logic [2:0]  adc_ch,
  input  logic        adc_done,
  input  logic [11:0] adc_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        frame_active,
  output logic        overrun,
  output logic        adc_timeout
);

  localparam int unsigned CNT_W  = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int unsigned CH_W   = 3;
  localparam int unsigned DATA_W = 12;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV_REQ,
    S_CONV_WAIT,
    S_SEND_LB,
    S_SEND_UB,
    S_NEXT_CH,
    S_SEND_TERM
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    per_cnt_q, per_cnt_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [DATA_W-1:0]   result_q, result_d;

  logic                adc_start_q, adc_start_d;
  logic [CH_W-1:0]     adc_ch_q, adc_ch_d;
  logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic                frame_active_q, frame_active_d;
  logic                overrun_q, overrun_d;

  logic                tick_c;
  logic                xfer_c;
  logic                last_ch_c;
  logic                conv_done_c;
  logic                timeout_c;
  logic                conv_end_c;

  assign tick_c      = enable && (per_cnt_q == CNT_W'(PERIOD_CYCLES - 1));
  assign xfer_c      = tx_valid_q && tx_ready;
  assign last_ch_c   = (ch_q == CH_W'(NUM_CH - 1));
  assign conv_done_c = (state_q == S_CONV_WAIT) && adc_done;
  assign conv_end_c  = conv_done_c || timeout_c;

`ifdef ADC_FRAME_SCHED_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            timeout_flag_q, timeout_flag_d;

  // Wait counter restarts at 0 on every CONV_WAIT entry; done in the same cycle beats timeout
  always_comb begin
    wait_cnt_d     = '0;
    timeout_c      = 1'b0;
    timeout_flag_d = timeout_flag_q;
    if (state_q == S_CONV_WAIT) begin
      wait_cnt_d = TO_W'(wait_cnt_q + TO_W'(1));
      timeout_c  = !adc_done && (wait_cnt_q == TO_W'(TIMEOUT_CYCLES));
    end
    if (timeout_c) begin
      timeout_flag_d = 1'b1;
    end
  end

  // Timeout counter and sticky flag registers
  always_ff @(posedge clk_50) begin
    if (reset) begin
      wait_cnt_q     <= '0;
      timeout_flag_q <= 1'b0;
    end else begin
      wait_cnt_q     <= wait_cnt_d;
      timeout_flag_q <= timeout_flag_d;
    end
  end

  assign adc_timeout = timeout_flag_q;
`else
  assign timeout_c   = 1'b0;
  assign adc_timeout = 1'b0;
`endif

  // Period counter: free-runs while enabled, parked at 0 otherwise
  always_comb begin
    per_cnt_d = per_cnt_q;
    if (!enable || tick_c) begin
      per_cnt_d = '0;
    end else begin
      per_cnt_d = CNT_W'(per_cnt_q + CNT_W'(1));
    end
  end

  // FSM state register
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: byte states advance only on an accepted transfer
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (tick_c)     state_d = S_CONV_REQ;
      S_CONV_REQ:                  state_d = S_CONV_WAIT;
      S_CONV_WAIT: if (conv_end_c) state_d = S_SEND_LB;
      S_SEND_LB:   if (xfer_c)     state_d = S_SEND_UB;
      S_SEND_UB:   if (xfer_c)     state_d = S_NEXT_CH;
      S_NEXT_CH:   state_d = last_ch_c ? S_SEND_TERM : S_CONV_REQ;
      S_SEND_TERM: if (xfer_c)     state_d = S_IDLE;
      default:                     state_d = S_IDLE;
    endcase
  end

  // Channel index and captured conversion result
  always_comb begin
    ch_d     = ch_q;
    result_d = result_q;
    if ((state_q == S_IDLE) && tick_c) begin
      ch_d = '0;
    end else if ((state_q == S_NEXT_CH) && !last_ch_c) begin
      ch_d = CH_W'(ch_q + CH_W'(1));
    end
    if (conv_done_c) begin
      result_d = adc_data;
    end else if (timeout_c) begin
      result_d = {DATA_W{1'b1}};
    end
  end

  // Output decode from the upcoming state so every output is registered yet cycle-aligned
  always_comb begin
    adc_start_d    = (state_d == S_CONV_REQ);
    adc_ch_d       = ch_d;
    frame_active_d = (state_d != S_IDLE);
    tx_valid_d     = 1'b0;
    tx_data_d      = '0;
    case (state_d)
      S_SEND_LB: begin
        tx_valid_d = 1'b1;
        tx_data_d  = result_d[7:0];
      end
      S_SEND_UB: begin
        tx_valid_d = 1'b1;
        tx_data_d  = {1'b0, ch_d, result_d[11:8]};
      end
      S_SEND_TERM: begin
        tx_valid_d = 1'b1;
        tx_data_d  = TERM_BYTE;
      end
      default: begin
        tx_valid_d = 1'b0;
        tx_data_d  = '0;
      end
    endcase
    // A tick during an active frame is dropped but flagged; set beats clear
    overrun_d = overrun_q;
    if (tick_c && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk_50) begin
    if (reset) begin
      per_cnt_q      <= '0;
      ch_q           <= '0;
      result_q       <= '0;
      adc_start_q    <= 1'b0;
      adc_ch_q       <= '0;
      tx_data_q      <= '0;
      tx_valid_q     <= 1'b0;
      frame_active_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      per_cnt_q      <= per_cnt_d;
      ch_q           <= ch_d;
      result_q       <= result_d;
      adc_start_q    <= adc_start_d;
      adc_ch_q       <= adc_ch_d;
      tx_data_q      <= tx_data_d;
      tx_valid_q     <= tx_valid_d;
      frame_active_q <= frame_active_d;
      overrun_q      <= overrun_d;
    end
  end

  assign adc_start    = adc_start_q;
  assign adc_ch       = adc_ch_q;
  assign tx_data      = tx_data_q;
  assign tx_valid     = tx_valid_q;
  assign frame_active = frame_active_q;
  assign overrun      = overrun_q;

endmodule
